// File: rtl/data_cache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache:
// FSM states, load/store size codes and line geometry.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } dcache_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int OFFSET_W = 4;
  localparam int LINE_W   = 128;

endpackage

// File: rtl/data_cache_if.sv
// CPU data port and backing-memory line port of the data cache, bundled.
// master = CPU plus backing memory side, slave = the cache.
interface data_cache_if;
  import dcache_pkg::*;

  logic [3:0]        DATA_MEM_READ;
  logic [2:0]        DATA_MEM_WRITE;
  logic [31:0]       DATA_MEM_ADDR;
  logic [31:0]       DATA_MEM_WRITE_DATA;
  logic [31:0]       DATA_MEM_READ_DATA;
  logic              DATA_MEM_BUSYWAIT;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [27:0]       MEM_ADDRESS;
  logic [LINE_W-1:0] MEM_WRITEDATA;
  logic [LINE_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;

  modport master (
    output DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
    output MEM_READDATA, MEM_BUSYWAIT,
    input  DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport slave (
    input  DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
    input  MEM_READDATA, MEM_BUSYWAIT,
    output DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

endinterface

// File: rtl/data_cache_align_unit.sv
// Combinational byte/half/word load extraction with extension, and store
// merge into a 128-bit line. Sub-word fields ignore the low address bits.
module dcache_align_unit
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0]   line_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic [2:0]          load_funct3_i,
  input  logic [1:0]          store_size_i,
  input  logic [31:0]         store_data_i,
  output logic [31:0]         load_data_o,
  output logic                load_ok_o,
  output logic [LINE_W-1:0]   merged_line_o,
  output logic                store_ok_o
);

  logic [31:0] word_sel;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    word_sel = line_i[{offset_i[3:2], 5'b0} +: 32];
    half_sel = line_i[{offset_i[3:1], 4'b0} +: 16];
    byte_sel = line_i[{offset_i, 3'b0} +: 8];

    load_ok_o   = 1'b1;
    load_data_o = '0;
    case (load_funct3_i)
      F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data_o = word_sel;
      F3_LBU:  load_data_o = {24'b0, byte_sel};
      F3_LHU:  load_data_o = {16'b0, half_sel};
      default: load_ok_o   = 1'b0;
    endcase

    merged_line_o = line_i;
    store_ok_o    = 1'b1;
    case (store_size_i)
      SZ_B:    merged_line_o[{offset_i, 3'b0} +: 8]        = store_data_i[7:0];
      SZ_H:    merged_line_o[{offset_i[3:1], 4'b0} +: 16]  = store_data_i[15:0];
      SZ_W:    merged_line_o[{offset_i[3:2], 5'b0} +: 32]  = store_data_i;
      default: store_ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU MEM
// stage and line-wide backing memory. Optional DCACHE_STATS_EN adds hit/miss counters.
module data_cache
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int LINE_BYTES = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  data_cache_if.slave  bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  localparam int LINES     = 1 << INDEX_BITS;
  localparam int TAG_W     = 32 - INDEX_BITS - OFFSET_W;
  localparam int LINE_BITS = LINE_BYTES * 8;

  dcache_state_e        state_q;
  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];
  logic [LINE_BITS-1:0] fill_q;
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic [27:0]          mem_addr_q;
  logic [LINE_BITS-1:0] mem_wdata_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  is_write;
  logic                  is_read;
  logic                  req;
  logic                  op_ok;
  logic                  tag_match;
  logic                  hit;
  logic                  busy;
  logic [31:0]           load_data;
  logic                  load_ok;
  logic                  store_ok;
  logic [LINE_BITS-1:0]  merged_line;

  dcache_align_unit u_align (
    .line_i        (data_q[idx]),
    .offset_i      (bus.DATA_MEM_ADDR[OFFSET_W-1:0]),
    .load_funct3_i (bus.DATA_MEM_READ[2:0]),
    .store_size_i  (bus.DATA_MEM_WRITE[1:0]),
    .store_data_i  (bus.DATA_MEM_WRITE_DATA),
    .load_data_o   (load_data),
    .load_ok_o     (load_ok),
    .merged_line_o (merged_line),
    .store_ok_o    (store_ok)
  );

  // A write wins when both enables are high; an undefined code counts as a hit.
  always_comb begin
    idx       = bus.DATA_MEM_ADDR[INDEX_BITS+OFFSET_W-1:OFFSET_W];
    req_tag   = bus.DATA_MEM_ADDR[31:INDEX_BITS+OFFSET_W];
    is_write  = bus.DATA_MEM_WRITE[2];
    is_read   = bus.DATA_MEM_READ[3] & ~is_write;
    req       = bus.DATA_MEM_READ[3] | is_write;
    op_ok     = is_write ? store_ok : load_ok;
    tag_match = valid_q[idx] && (tag_q[idx] == req_tag);
    hit       = tag_match | ~op_ok;
    busy      = ~RESET & req & (~hit | (state_q != IDLE));
  end

  assign bus.DATA_MEM_BUSYWAIT  = busy;
  assign bus.DATA_MEM_READ_DATA = (~RESET & is_read & ~busy & tag_match & load_ok)
                                  ? load_data : 32'b0;
  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !hit) begin
            if (valid_q[idx] && dirty_q[idx]) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[idx], idx};
              mem_wdata_q <= data_q[idx];
            end else begin
              state_q    <= FETCH;
              mem_read_q <= 1'b1;
              mem_addr_q <= bus.DATA_MEM_ADDR[31:OFFSET_W];
            end
          end else if (req && is_write && store_ok) begin
            data_q[idx]  <= merged_line;
            dirty_q[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (!bus.MEM_BUSYWAIT) begin
            state_q     <= FETCH;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= bus.DATA_MEM_ADDR[31:OFFSET_W];
          end
        end
        FETCH: begin
          if (!bus.MEM_BUSYWAIT) begin
            state_q    <= UPDATE;
            mem_read_q <= 1'b0;
            fill_q     <= bus.MEM_READDATA;
          end
        end
        UPDATE: begin
          state_q      <= IDLE;
          data_q[idx]  <= fill_q;
          tag_q[idx]   <= req_tag;
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // Every IDLE miss leaves IDLE on the same edge, so it is one miss event.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else if (state_q == IDLE && req) begin
      if (hit) HIT_COUNT  <= HIT_COUNT + 32'd1;
      else     MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed CPU accesses push expected load
// data and backing-memory transactions; monitors pop and compare them.
module tb_data_cache;
  import dcache_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  data_cache_if bus();

  data_cache #(.INDEX_BITS(3), .LINE_BYTES(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } mem_txn_t;

  mem_txn_t     mem_exp[$];
  logic [31:0]  rd_exp[$];
  logic [127:0] mem_model [logic [27:0]];

  localparam int MEM_LAT = 2;
  int unsigned mem_cnt = 0;

  localparam logic [3:0] LB  = 4'b1000;
  localparam logic [3:0] LH  = 4'b1001;
  localparam logic [3:0] LW  = 4'b1010;
  localparam logic [3:0] LBU = 4'b1100;
  localparam logic [3:0] LHU = 4'b1101;
  localparam logic [2:0] SB  = 3'b100;
  localparam logic [2:0] SH  = 3'b101;
  localparam logic [2:0] SW  = 3'b110;

  localparam logic [127:0] LINE_A = {32'h0F1E2D3C, 32'hCAFEF00D, 32'h76543210, 32'h8899AABB};
  localparam logic [127:0] LINE_B = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFF0000, 32'h13579BDF};
  localparam logic [127:0] LINE_M = {32'h01020304, 32'hCAFEF00D, 32'hABCD3210, 32'h88995A77};

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endfunction

  // Backing memory: busy for MEM_LAT cycles per transfer, then completes.
  assign bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && (mem_cnt < MEM_LAT);

  always @(posedge CLK) begin
    if ((bus.MEM_READ | bus.MEM_WRITE) && bus.MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  initial begin
    mem_txn_t e;
    bus.MEM_READDATA = '0;
    forever begin
      @(negedge CLK);
      if (!RESET && (bus.MEM_READ || bus.MEM_WRITE) && !bus.MEM_BUSYWAIT) begin
        if (mem_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected: got wr=%0b addr=%0h want none", bus.MEM_WRITE, bus.MEM_ADDRESS);
        end else begin
          e = mem_exp.pop_front();
          check("mem_kind", {bus.MEM_READ, bus.MEM_WRITE}, {~e.wr, e.wr});
          check("mem_addr", bus.MEM_ADDRESS, e.addr);
          if (e.wr) check("mem_wdata", bus.MEM_WRITEDATA, e.data);
        end
        if (bus.MEM_WRITE) mem_model[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
      end
      bus.MEM_READDATA = mem_model.exists(bus.MEM_ADDRESS) ? mem_model[bus.MEM_ADDRESS] : '0;
    end
  end

  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge CLK);
      if (!RESET && bus.DATA_MEM_READ[3] && !bus.DATA_MEM_WRITE[2] && !bus.DATA_MEM_BUSYWAIT) begin
        if (rd_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got=%0h want none", bus.DATA_MEM_READ_DATA);
        end else begin
          exp = rd_exp.pop_front();
          check("rd_data", bus.DATA_MEM_READ_DATA, exp);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.DATA_MEM_READ       = '0;
    bus.DATA_MEM_WRITE      = '0;
    bus.DATA_MEM_ADDR       = '0;
    bus.DATA_MEM_WRITE_DATA = '0;
  endtask

  // Called at posedge+1; holds the request until BUSYWAIT is seen low.
  task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_busy, input string name);
    int cyc = 0;
    bus.DATA_MEM_READ       = rd;
    bus.DATA_MEM_WRITE      = wr;
    bus.DATA_MEM_ADDR       = addr;
    bus.DATA_MEM_WRITE_DATA = wdata;
    forever begin
      @(negedge CLK);
      if (!bus.DATA_MEM_BUSYWAIT) break;
      cyc++;
      if (cyc > 100) break;
    end
    check(name, cyc, exp_busy);
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  task automatic load(input logic [3:0] rd, input logic [31:0] addr, input logic [31:0] exp,
                      input int exp_busy, input string name);
    rd_exp.push_back(exp);
    access(rd, 3'b000, addr, 32'h0, exp_busy, name);
  endtask

  task automatic store(input logic [2:0] wr, input logic [31:0] addr, input logic [31:0] data,
                       input string name);
    access(4'b0000, wr, addr, data, 0, name);
  endtask

  task automatic exp_mem(input bit wr, input logic [27:0] addr, input logic [127:0] data);
    mem_txn_t t;
    t.wr = wr; t.addr = addr; t.data = data;
    mem_exp.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    mem_model[28'h0000004] = LINE_A;
    mem_model[28'h0000014] = LINE_B;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_read_data", bus.DATA_MEM_READ_DATA, 32'h0);
    check("rst_busywait", bus.DATA_MEM_BUSYWAIT, 1'b0);
    check("rst_mem_read", bus.MEM_READ, 1'b0);
    check("rst_mem_write", bus.MEM_WRITE, 1'b0);
    check("rst_mem_addr", bus.MEM_ADDRESS, 28'h0);
    check("rst_mem_wdata", bus.MEM_WRITEDATA, 128'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Clean miss: 1 IDLE + 3 FETCH (2 busy) + 1 UPDATE.
    exp_mem(1'b0, 28'h0000004, '0);
    load(LW, 32'h40, 32'h8899AABB, 5, "busy_lw40_clean_miss");

    load(LW,  32'h40, 32'h8899AABB, 0, "busy_lw40_hit");
    load(LB,  32'h43, 32'hFFFFFF88, 0, "busy_lb43");
    load(LBU, 32'h43, 32'h00000088, 0, "busy_lbu43");
    load(LH,  32'h42, 32'hFFFF8899, 0, "busy_lh42");
    load(LHU, 32'h42, 32'h00008899, 0, "busy_lhu42");
    load(LHU, 32'h43, 32'h00008899, 0, "busy_lhu43_unaligned");
    load(LW,  32'h43, 32'h8899AABB, 0, "busy_lw43_unaligned");
    load(LW,  32'h4C, 32'h0F1E2D3C, 0, "busy_lw4c");
    load(LH,  32'h46, 32'h00007654, 0, "busy_lh46");
    load(LB,  32'h4B, 32'hFFFFFFCA, 0, "busy_lb4b");

    store(SB, 32'h41, 32'h0000005A, "busy_sb41");
    @(negedge CLK);
    check("no_mem_write_on_hit", bus.MEM_WRITE, 1'b0);
    @(posedge CLK); #1;
    load(LW, 32'h40, 32'h88995ABB, 0, "busy_lw40_after_sb");

    store(SH, 32'h47, 32'h1234ABCD, "busy_sh47");
    load(LW, 32'h44, 32'hABCD3210, 0, "busy_lw44_after_sh");
    store(SW, 32'h4F, 32'h01020304, "busy_sw4f");
    load(LW, 32'h4C, 32'h01020304, 0, "busy_lw4c_after_sw");

    // Read and write together: the write wins, no load data is checked.
    access(LW, SB, 32'h40, 32'h00000077, 0, "busy_rd_wr_both");
    load(LW, 32'h40, 32'h88995A77, 0, "busy_lw40_after_both");

    // Undefined codes: hit with no effect even on a non-resident address.
    load(4'b1011, 32'h200, 32'h0, 0, "busy_undef_funct3");
    store(3'b111, 32'h200, 32'hFFFFFFFF, "busy_undef_size");

    // Dirty miss: writeback of the merged line, then fetch of the new tag.
    exp_mem(1'b1, 28'h0000004, LINE_M);
    exp_mem(1'b0, 28'h0000014, '0);
    load(LW, 32'h140, 32'h13579BDF, 8, "busy_lw140_dirty_miss");
    load(LB, 32'h140, 32'hFFFFFFDF, 0, "busy_lb140_hit");

    // Reset in FETCH abandons the fill.
    bus.DATA_MEM_READ = LW;
    bus.DATA_MEM_ADDR = 32'h40;
    @(negedge CLK);
    check("rf_busy_idle_miss", bus.DATA_MEM_BUSYWAIT, 1'b1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rf_mem_read_fetch", bus.MEM_READ, 1'b1);
    check("rf_mem_addr_fetch", bus.MEM_ADDRESS, 28'h0000004);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rf_mem_read_dropped", bus.MEM_READ, 1'b0);
    check("rf_mem_write_low", bus.MEM_WRITE, 1'b0);
    check("rf_busy_in_reset", bus.DATA_MEM_BUSYWAIT, 1'b0);
    check("rf_rdata_in_reset", bus.DATA_MEM_READ_DATA, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    idle_inputs();

    exp_mem(1'b0, 28'h0000004, '0);
    load(LW, 32'h40, 32'h88995A77, 5, "busy_lw40_after_reset");
    exp_mem(1'b0, 28'h0000014, '0);
    load(LW, 32'h140, 32'h13579BDF, 5, "busy_lw140_after_reset");

    repeat (3) @(posedge CLK);
    check("rd_queue_drained", rd_exp.size(), 0);
    check("mem_queue_drained", mem_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
